// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase controller.
// Contents:
//   phase_t     - controller phase enumeration
//   RED/YEL/GRN - one-hot lamp encodings, bit order {red, yellow, green}
//   lamp_t      - lamp set for one phase (NS lamps, EW lamps, walk lamp)
//   phase_lamps - maps a phase to the lamps it must show
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        CLEAR_A   = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        CLEAR_B   = 3'd5,
        PED_WALK  = 3'd6
    } phase_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
    } lamp_t;

    // Any phase not listed (including unused encodings) shows all red.
    function automatic lamp_t phase_lamps(input phase_t p);
        lamp_t l;
        l.ns   = RED;
        l.ew   = RED;
        l.walk = 1'b0;
        case (p)
            NS_GREEN:  l.ns   = GRN;
            NS_YELLOW: l.ns   = YEL;
            EW_GREEN:  l.ew   = GRN;
            EW_YELLOW: l.ew   = YEL;
            PED_WALK:  l.walk = 1'b1;
            default:   l.walk = 1'b0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/intersection_phase_fsm.sv
// Intersection phase controller: sequences NS green/yellow, all-red clearance,
// EW green/yellow, all-red clearance and an optional pedestrian walk phase.
// Green/yellow durations come from external timers via start/done handshakes.
// Ports:
//   clk         - system clock, rising edge
//   reset       - synchronous active-high reset
//   greenDone   - green timer expired (ignored outside a green phase / start cycle)
//   yellowDone  - yellow timer expired (ignored outside a yellow phase / start cycle)
//   pedRequest  - pedestrian button, level or pulse
//   greenStart  - one-cycle start pulse to the green timer
//   yellowStart - one-cycle start pulse to the yellow timer
//   nsLights    - NS lamps {red, yellow, green}, one-hot
//   ewLights    - EW lamps {red, yellow, green}, one-hot
//   walk        - pedestrian walk lamp
module intersection_phase_fsm
    import traffic_pkg::*;
#(
    parameter int ALL_RED_CYCLES = 2,
    parameter int WALK_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       greenDone,
    input  logic       yellowDone,
    input  logic       pedRequest,
    output logic       greenStart,
    output logic       yellowStart,
    output logic [2:0] nsLights,
    output logic [2:0] ewLights,
    output logic       walk
);

    // Terminal counts; a parameter of 0 behaves like 1.
    localparam logic [14:0] ALL_RED_LAST =
        (ALL_RED_CYCLES <= 1) ? 15'd0 : 15'(ALL_RED_CYCLES - 1);
    localparam logic [14:0] WALK_LAST =
        (WALK_CYCLES <= 1) ? 15'd0 : 15'(WALK_CYCLES - 1);

    phase_t      state_r;
    phase_t      next_state_s;
    logic [14:0] cnt_r;
    logic        pending_r;
    logic        ped_go_s;
    logic        entering_s;
    lamp_t       next_lamps_s;

    // Next-phase selection. Done flags are only honoured after the start
    // pulse cycle, so a done held high advances exactly one phase per timer.
    always_comb begin
        next_state_s = state_r;
        ped_go_s     = pending_r | pedRequest;
        case (state_r)
            NS_GREEN: begin
                if (greenDone && !greenStart) next_state_s = NS_YELLOW;
                else                          next_state_s = state_r;
            end
            NS_YELLOW: begin
                if (yellowDone && !yellowStart) next_state_s = CLEAR_A;
                else                            next_state_s = state_r;
            end
            CLEAR_A: begin
                if (cnt_r >= ALL_RED_LAST) next_state_s = EW_GREEN;
                else                       next_state_s = state_r;
            end
            EW_GREEN: begin
                if (greenDone && !greenStart) next_state_s = EW_YELLOW;
                else                          next_state_s = state_r;
            end
            EW_YELLOW: begin
                if (yellowDone && !yellowStart) next_state_s = CLEAR_B;
                else                            next_state_s = state_r;
            end
            CLEAR_B: begin
                // A request arriving in the decision cycle itself still counts.
                if (cnt_r >= ALL_RED_LAST) next_state_s = ped_go_s ? PED_WALK : NS_GREEN;
                else                       next_state_s = state_r;
            end
            PED_WALK: begin
                if (cnt_r >= WALK_LAST) next_state_s = NS_GREEN;
                else                    next_state_s = state_r;
            end
            default: next_state_s = CLEAR_B;
        endcase
        entering_s   = (next_state_s != state_r);
        next_lamps_s = phase_lamps(next_state_s);
    end

    // State, counter, pending flag and registered outputs. Outputs are decoded
    // from the next phase so they line up with the phase register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= CLEAR_B;
            cnt_r       <= 15'd0;
            pending_r   <= 1'b0;
            greenStart  <= 1'b0;
            yellowStart <= 1'b0;
            nsLights    <= RED;
            ewLights    <= RED;
            walk        <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cnt_r       <= entering_s ? 15'd0 : cnt_r + 15'd1;
            // Cleared only on entry to the walk, so a press during the walk
            // is kept for the following cycle.
            pending_r   <= (entering_s && next_state_s == PED_WALK) ? 1'b0
                                                                    : (pending_r | pedRequest);
            greenStart  <= entering_s && (next_state_s == NS_GREEN || next_state_s == EW_GREEN);
            yellowStart <= entering_s && (next_state_s == NS_YELLOW || next_state_s == EW_YELLOW);
            nsLights    <= next_lamps_s.ns;
            ewLights    <= next_lamps_s.ew;
            walk        <= next_lamps_s.walk;
        end
    end

endmodule

// File: tb/tb_intersection_phase_fsm.sv
// Randomised scoreboard bench for intersection_phase_fsm.
module tb_intersection_phase_fsm;

    localparam int AR = 2;
    localparam int WK = 4;

    // Reference phases, named independently of the design's encoding.
    localparam int P_NSG  = 10;
    localparam int P_NSY  = 11;
    localparam int P_CLA  = 12;
    localparam int P_EWG  = 13;
    localparam int P_EWY  = 14;
    localparam int P_CLB  = 15;
    localparam int P_WALK = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       greenDone = 1'b0;
    logic       yellowDone = 1'b0;
    logic       pedRequest = 1'b0;
    logic       greenStart;
    logic       yellowStart;
    logic [2:0] nsLights;
    logic [2:0] ewLights;
    logic       walk;

    intersection_phase_fsm #(.ALL_RED_CYCLES(AR), .WALK_CYCLES(WK)) dut (
        .clk        (clk),
        .reset      (reset),
        .greenDone  (greenDone),
        .yellowDone (yellowDone),
        .pedRequest (pedRequest),
        .greenStart (greenStart),
        .yellowStart(yellowStart),
        .nsLights   (nsLights),
        .ewLights   (ewLights),
        .walk       (walk)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       wlk;
        logic       gs;
        logic       ys;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: current phase, cycles spent in it, pending request.
    int   m_phase = P_CLB;
    int   m_age   = 0;
    bit   m_pend  = 1'b0;

    function automatic exp_t expect_for(input int ph, input int age);
        exp_t e;
        e.ns  = 3'b100;
        e.ew  = 3'b100;
        e.wlk = 1'b0;
        if (ph == P_NSG) e.ns = 3'b001;
        if (ph == P_NSY) e.ns = 3'b010;
        if (ph == P_EWG) e.ew = 3'b001;
        if (ph == P_EWY) e.ew = 3'b010;
        if (ph == P_WALK) e.wlk = 1'b1;
        e.gs = (ph == P_NSG || ph == P_EWG) && (age == 0);
        e.ys = (ph == P_NSY || ph == P_EWY) && (age == 0);
        return e;
    endfunction

    function automatic void check(input string name, input logic [2:0] act, input logic [2:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Advance the model by one clock with the given inputs.
    function automatic void model_step(input bit r, input bit g, input bit y, input bit p);
        int  nxt;
        bit  ex;
        int  ar_len;
        int  wk_len;
        ar_len = (AR < 1) ? 1 : AR;
        wk_len = (WK < 1) ? 1 : WK;
        if (r) begin
            m_phase = P_CLB;
            m_age   = 0;
            m_pend  = 1'b0;
            return;
        end
        ex  = 1'b0;
        nxt = m_phase;
        case (m_phase)
            P_NSG:  begin ex = g && m_age > 0;          nxt = P_NSY; end
            P_NSY:  begin ex = y && m_age > 0;          nxt = P_CLA; end
            P_CLA:  begin ex = (m_age + 1 >= ar_len);   nxt = P_EWG; end
            P_EWG:  begin ex = g && m_age > 0;          nxt = P_EWY; end
            P_EWY:  begin ex = y && m_age > 0;          nxt = P_CLB; end
            P_CLB:  begin ex = (m_age + 1 >= ar_len);   nxt = (m_pend || p) ? P_WALK : P_NSG; end
            default: begin ex = (m_age + 1 >= wk_len);  nxt = P_NSG; end
        endcase
        m_pend = (ex && nxt == P_WALK) ? 1'b0 : (m_pend | p);
        if (ex) begin
            m_phase = nxt;
            m_age   = 0;
        end else begin
            m_age++;
        end
    endfunction

    // Drive inputs away from the active edge and queue the response due after it.
    task automatic step(input bit r, input bit g, input bit y, input bit p);
        @(negedge clk);
        reset      = r;
        greenDone  = g;
        yellowDone = y;
        pedRequest = p;
        model_step(r, g, y, p);
        exp_q.push_back(expect_for(m_phase, m_age));
    endtask

    // Monitor: the DUT presents outputs every cycle; compare just after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("nsLights",    nsLights,            e.ns);
            check("ewLights",    ewLights,            e.ew);
            check("walk",        {2'b00, walk},        {2'b00, e.wlk});
            check("greenStart",  {2'b00, greenStart},  {2'b00, e.gs});
            check("yellowStart", {2'b00, yellowStart}, {2'b00, e.ys});
            check("ns_onehot",   {2'b00, $onehot(nsLights)}, 3'b001);
            check("ew_onehot",   {2'b00, $onehot(ewLights)}, 3'b001);
            check("no_conflict", {2'b00, (nsLights != 3'b100) && (ewLights != 3'b100)}, 3'b000);
        end
    end

    initial begin
        int  walk_cycles;
        // Reset for 4 cycles, then free-run with no requests.
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (80) step(1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 1'b0);

        // Random timers and sparse pedestrian pulses.
        repeat (400) step(1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 15) == 0);

        // Both done flags tied high.
        repeat (100) step(1'b0, 1'b1, 1'b1, $urandom_range(0, 7) == 0);

        // Pedestrian button held continuously.
        repeat (150) step(1'b0, $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, 1'b1);

        // Reset landing in EW yellow, after setting a pending request.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 200 && m_phase != P_EWG; i++)
                step(1'b0, $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 200 && m_phase != P_EWY; i++)
                step(1'b0, $urandom_range(0, 1) == 0, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b1, 1'b0);
            repeat (60) step(1'b0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 1'b0);
        end

        // Random resets sprinkled over random traffic.
        repeat (300) step($urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 10) == 0);

        // Drain the scoreboard within a bounded number of cycles.
        walk_cycles = 0;
        while (exp_q.size() > 0 && walk_cycles < 10) begin
            @(posedge clk);
            #2;
            walk_cycles++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/intersection_phase_fsm.md
INTERSECTION_PHASE_FSM -- requirements
Module: intersection_phase_fsm

Interface
REQ-001 SHALL have parameter ALL_RED_CYCLES, default 2, giving the all-red clearance length in clk cycles.
REQ-002 SHALL have parameter WALK_CYCLES, default 4, giving the pedestrian walk length in clk cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port greenDone, input, 1 bit: completion flag from the green light timer.
REQ-006 SHALL have port yellowDone, input, 1 bit: completion flag from the yellow light timer.
REQ-007 SHALL have port pedRequest, input, 1 bit: pedestrian button; level or pulse.
REQ-008 SHALL have port greenStart, output, 1 bit: one-cycle start pulse to the green timer.
REQ-009 SHALL have port yellowStart, output, 1 bit: one-cycle start pulse to the yellow timer.
REQ-010 SHALL have port nsLights, output, 3 bits: north-south lamps {red, yellow, green}, one-hot.
REQ-011 SHALL have port ewLights, output, 3 bits: east-west lamps {red, yellow, green}, one-hot.
REQ-012 SHALL have port walk, output, 1 bit: pedestrian walk lamp.

Function
REQ-013 SHALL implement states NS_GREEN, NS_YELLOW, CLEAR_A, EW_GREEN, EW_YELLOW, CLEAR_B, PED_WALK.
REQ-014 Transitions SHALL be: CLEAR_B->NS_GREEN, then NS_GREEN->NS_YELLOW on greenDone.
REQ-015 Transitions SHALL continue: NS_YELLOW->CLEAR_A on yellowDone, then CLEAR_A->EW_GREEN after ALL_RED_CYCLES.
REQ-016 Transitions SHALL continue: EW_GREEN->EW_YELLOW on greenDone, then EW_YELLOW->CLEAR_B on yellowDone.
REQ-017 CLEAR_B SHALL exit after ALL_RED_CYCLES: to PED_WALK if a request is pending, else to NS_GREEN.
REQ-018 PED_WALK SHALL last WALK_CYCLES, then go to NS_GREEN.
REQ-019 greenStart/yellowStart SHALL be registered and high for exactly the first cycle of each green/yellow state.
REQ-020 greenDone/yellowDone SHALL be ignored during the start-pulse cycle and in any state other than the matching green/yellow state.
REQ-021 Lamp outputs SHALL be registered and one-hot in every cycle.
REQ-022 Lamp outputs SHALL show red for the non-served direction, and red for both directions in CLEAR_A, CLEAR_B and PED_WALK.
REQ-023 The two directions SHALL never show non-red simultaneously.
REQ-024 walk SHALL be 1 only in PED_WALK.
REQ-025 A 15-bit clearance/walk counter SHALL clear on state entry and increment each cycle.
REQ-026 The counter SHALL force the exit when it reaches ALL_RED_CYCLES-1 or WALK_CYCLES-1; a parameter value of 0 SHALL be treated as 1.
REQ-027 pedRequest SHALL set a sticky pending flag that is cleared on entry to PED_WALK.
REQ-028 A request arriving during PED_WALK SHALL be held for the next cycle.
REQ-029 A request arriving in the same cycle the CLEAR_B decision is made SHALL be honoured.
REQ-030 Any done signal held high indefinitely SHALL advance at most one state per timer phase, with no skipping.

Reset
REQ-031 reset SHALL force state CLEAR_B with the counter at 0.
REQ-032 reset SHALL force nsLights=ewLights=3'b100, walk=0, greenStart=yellowStart=0, and pending=0.
REQ-033 reset asserted mid-phase SHALL take effect on the next edge regardless of the timers.
REQ-034 The first green after reset release SHALL be NS, following ALL_RED_CYCLES of all-red.

Structure
REQ-035 The state enum and the lamp encodings (RED=3'b100, YEL=3'b010, GRN=3'b001) SHALL live in shared package traffic_pkg.
REQ-036 The block SHALL be a single module with no sub-module; the green/yellow timers stay external, one instance each.

Verification
REQ-037 Scenario: reset 4 cycles, then release with timers at SET=5/3 -> 2 all-red cycles, greenStart pulse, NS green 6 cycles, yellowStart pulse.
REQ-038 Scenario: full cycle with no pedRequest -> order NS_G, NS_Y, CLEAR_A, EW_G, EW_Y, CLEAR_B, NS_G; both directions never non-red together.
REQ-039 Scenario: 1-cycle pedRequest pulse during EW_GREEN -> after CLEAR_B, walk=1 for exactly 4 cycles, then NS green.
REQ-040 Scenario: greenDone tied high -> each green lasts exactly 2 cycles (start cycle plus one) and no state is skipped.
REQ-041 Scenario: reset asserted during EW_YELLOW -> next cycle all red, walk=0, pending cleared, no start pulses.
REQ-042 Scenario: pedRequest held high continuously -> PED_WALK follows every CLEAR_B and NS green is still served each cycle.
